// File: rtl/jedro_1_test_monitor.sv
// -----------------------------------------------------------------------------
// jedro_1_test_monitor
//
// Run-and-check monitor for jedro_1 directed instruction tests. The monitor
// lets the core run until the decoder flags an illegal instruction (used as a
// halt) or a cycle budget expires. It then waits a few cycles so the pipeline
// can drain. Finally it walks a small programmable expectation table and
// compares each enabled entry against the register file through its
// synchronous read port.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   start_i              start a run (accepted in IDLE or DONE)
//   illegal_instr_i      halt indication from the decoder (sampled in RUN only)
//   exp_we_i/idx/valid/addr/data
//                        expectation table write port (IDLE/DONE only)
//   rf_addr_o            registered regfile read address
//   rf_data_i            regfile read data, valid one cycle after rf_addr_o
//   busy_o, done_o       RUN/DRAIN/CHECK indication, DONE indication
//   pass_o, timeout_o    overall verdict, budget expired without halt
//   cycles_o             RUN cycles counted
//   fail_count_o         number of mismatching enabled entries
//   first_fail_idx_o     index of the first mismatching entry (0 if none)
// -----------------------------------------------------------------------------
module jedro_1_test_monitor #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_CHECKS     = 4,
    parameter int MAX_CYCLES     = 32,
    parameter int DRAIN_CYCLES   = 3,
    localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int CNT_W = $clog2(MAX_CYCLES + 1),
    localparam int FC_W  = $clog2(NUM_CHECKS + 1)
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      start_i,
    input  logic                      illegal_instr_i,
    input  logic                      exp_we_i,
    input  logic [IDX_W-1:0]          exp_idx_i,
    input  logic                      exp_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] exp_addr_i,
    input  logic [DATA_WIDTH-1:0]     exp_data_i,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr_o,
    input  logic [DATA_WIDTH-1:0]     rf_data_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic                      timeout_o,
    output logic [CNT_W-1:0]          cycles_o,
    output logic [FC_W-1:0]           fail_count_o,
    output logic [IDX_W-1:0]          first_fail_idx_o
);

    // Drain counter only needs to reach DRAIN_CYCLES-1; keep at least one bit.
    localparam int DC_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    // CHECK step counter runs 0..NUM_CHECKS+1.
    localparam int STEP_W = $clog2(NUM_CHECKS + 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e                    state_q;
    logic [CNT_W-1:0]          cycles_q;
    logic [DC_W-1:0]           drain_q;
    logic [STEP_W-1:0]         step_q;
    logic [REG_ADDR_WIDTH-1:0] rf_addr_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      pass_q;
    logic                      timeout_q;
    logic [FC_W-1:0]           fail_count_q;
    logic [IDX_W-1:0]          first_fail_q;

    logic                      exp_valid_q [NUM_CHECKS];
    logic [REG_ADDR_WIDTH-1:0] exp_addr_q  [NUM_CHECKS];
    logic [DATA_WIDTH-1:0]     exp_data_q  [NUM_CHECKS];

    logic                      tbl_wr_s;
    logic                      budget_end_s;
    logic                      drain_last_s;
    logic                      iss_en_s;
    logic [IDX_W-1:0]          iss_idx_s;
    logic                      mismatch_s;
    logic [IDX_W-1:0]          cmp_idx_s;

    // Table write qualifier: only while parked, and only for existing entries.
    always_comb begin
        tbl_wr_s = 1'b0;
        if (exp_we_i && ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
            (32'(exp_idx_i) < 32'(NUM_CHECKS))) begin
            tbl_wr_s = 1'b1;
        end else begin
            tbl_wr_s = 1'b0;
        end
    end

    // Expectation table storage; retained across runs, cleared only by reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                exp_valid_q[i] <= 1'b0;
                exp_addr_q[i]  <= '0;
                exp_data_q[i]  <= '0;
            end
        end else if (tbl_wr_s) begin
            exp_valid_q[exp_idx_i] <= exp_valid_i;
            exp_addr_q[exp_idx_i]  <= exp_addr_i;
            exp_data_q[exp_idx_i]  <= exp_data_i;
        end
    end

    // Budget and drain terminal conditions, evaluated on the current count.
    always_comb begin
        budget_end_s = (32'(cycles_q) + 32'd1 >= 32'(MAX_CYCLES));
        drain_last_s = (32'(drain_q) + 32'd1 >= 32'(DRAIN_CYCLES));
    end

    // CHECK pipeline: step s presents entry s; the entry presented in step s-1
    // is compared in step s because the regfile answers one cycle later.
    always_comb begin
        iss_en_s   = 1'b0;
        iss_idx_s  = '0;
        mismatch_s = 1'b0;
        cmp_idx_s  = '0;
        if (state_q == ST_CHECK) begin
            iss_en_s  = (32'(step_q) + 32'd1 < 32'(NUM_CHECKS));
            iss_idx_s = IDX_W'(step_q + STEP_W'(1'b1));
            if ((step_q != '0) && (32'(step_q) <= 32'(NUM_CHECKS))) begin
                cmp_idx_s  = IDX_W'(step_q - STEP_W'(1'b1));
                mismatch_s = exp_valid_q[cmp_idx_s] &&
                             (rf_data_i != exp_data_q[cmp_idx_s]);
            end else begin
                cmp_idx_s  = '0;
                mismatch_s = 1'b0;
            end
        end else begin
            iss_en_s   = 1'b0;
            iss_idx_s  = '0;
            mismatch_s = 1'b0;
            cmp_idx_s  = '0;
        end
    end

    // Main sequencer with all result outputs registered.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            cycles_q     <= '0;
            drain_q      <= '0;
            step_q       <= '0;
            rf_addr_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_count_q <= '0;
            first_fail_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q      <= ST_RUN;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        timeout_q    <= 1'b0;
                        cycles_q     <= '0;
                        fail_count_q <= '0;
                        first_fail_q <= '0;
                    end
                end
                ST_RUN: begin
                    cycles_q <= cycles_q + CNT_W'(1'b1);
                    // A halt in the same cycle the budget runs out is a halt.
                    if (illegal_instr_i || budget_end_s) begin
                        timeout_q <= !illegal_instr_i;
                        drain_q   <= '0;
                        step_q    <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            state_q   <= ST_CHECK;
                            rf_addr_q <= exp_addr_q[0];
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_last_s) begin
                        state_q   <= ST_CHECK;
                        step_q    <= '0;
                        rf_addr_q <= exp_addr_q[0];
                    end else begin
                        drain_q <= drain_q + DC_W'(1'b1);
                    end
                end
                ST_CHECK: begin
                    step_q <= step_q + STEP_W'(1'b1);
                    if (iss_en_s) begin
                        rf_addr_q <= exp_addr_q[iss_idx_s];
                    end
                    if (mismatch_s) begin
                        if (32'(fail_count_q) < 32'(NUM_CHECKS)) begin
                            fail_count_q <= fail_count_q + FC_W'(1'b1);
                        end
                        if (fail_count_q == '0) begin
                            first_fail_q <= cmp_idx_s;
                        end
                    end
                    // One settle step after the final compare, then publish.
                    if (32'(step_q) == 32'(NUM_CHECKS + 1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_count_q == '0) && !timeout_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rf_addr_o        = rf_addr_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign timeout_o        = timeout_q;
    assign cycles_o         = cycles_q;
    assign fail_count_o     = fail_count_q;
    assign first_fail_idx_o = first_fail_q;

endmodule

// File: tb/tb_jedro_1_test_monitor.sv
// -----------------------------------------------------------------------------
// tb_jedro_1_test_monitor
//
// Randomised bench for jedro_1_test_monitor. A synchronous register file
// model feeds rf_data_i. Expected results come from a table-level reference:
// count the enabled entries whose register value differs, take the first such
// index, and take the cycle count as min(halt cycle, budget).
// -----------------------------------------------------------------------------
module tb_jedro_1_test_monitor;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NC   = 4;
    localparam int MAXC = 32;
    localparam int DC   = 3;
    localparam int IW   = 2;
    localparam int CW   = 6;
    localparam int FW   = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          illegal = 1'b0;
    logic          exp_we = 1'b0;
    logic [IW-1:0] exp_idx = '0;
    logic          exp_valid = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_data = '0;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data = '0;
    logic          busy, done, pass, timeout;
    logic [CW-1:0] cycles;
    logic [FW-1:0] fail_count;
    logic [IW-1:0] first_fail;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] rf_mem [32];
    bit            mdl_valid [NC];
    logic [AW-1:0] mdl_addr  [NC];
    logic [DW-1:0] mdl_data  [NC];

    jedro_1_test_monitor #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_CHECKS(NC),
        .MAX_CYCLES(MAXC), .DRAIN_CYCLES(DC)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .illegal_instr_i(illegal),
        .exp_we_i(exp_we), .exp_idx_i(exp_idx), .exp_valid_i(exp_valid),
        .exp_addr_i(exp_addr), .exp_data_i(exp_data),
        .rf_addr_o(rf_addr), .rf_data_i(rf_data),
        .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout),
        .cycles_o(cycles), .fail_count_o(fail_count), .first_fail_idx_o(first_fail)
    );

    always #5 clk = ~clk;

    // Synchronous regfile read port: data follows the address by one cycle.
    always @(posedge clk) rf_data <= rf_mem[rf_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".rf_addr"}, 32'(rf_addr), 32'd0);
        check_val({tag, ".busy"}, 32'(busy), 32'd0);
        check_val({tag, ".done"}, 32'(done), 32'd0);
        check_val({tag, ".pass"}, 32'(pass), 32'd0);
        check_val({tag, ".timeout"}, 32'(timeout), 32'd0);
        check_val({tag, ".cycles"}, 32'(cycles), 32'd0);
        check_val({tag, ".fail_count"}, 32'(fail_count), 32'd0);
        check_val({tag, ".first_fail"}, 32'(first_fail), 32'd0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NC; i++) begin
            mdl_valid[i] = 1'b0;
            mdl_addr[i]  = '0;
            mdl_data[i]  = '0;
        end
    endtask

    // Writes one table entry; only called while the monitor is IDLE or DONE.
    task automatic wr_entry(input int idx, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_we    = 1'b1;
        exp_idx   = idx[IW-1:0];
        exp_valid = v;
        exp_addr  = a;
        exp_data  = d;
        @(posedge clk); #1;
        exp_we = 1'b0;
        mdl_valid[idx] = v;
        mdl_addr[idx]  = a;
        mdl_data[idx]  = d;
    endtask

    task automatic rand_table();
        logic [AW-1:0] a;
        for (int i = 0; i < NC; i++) begin
            a = AW'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0)
                wr_entry(i, ($urandom_range(0, 3) != 0), a, rf_mem[a] ^ ($urandom | 32'd1));
            else
                wr_entry(i, ($urandom_range(0, 3) != 0), a, rf_mem[a]);
        end
    endtask

    // One full run; halt_at = RUN cycle on which illegal is raised (0 = never).
    task automatic run_test(input string name, input int halt_at);
        int            exp_fc, exp_ff, halt_cyc, lat;
        bit            exp_to;
        logic [AW-1:0] wa;
        exp_fc = 0;
        exp_ff = 0;
        for (int i = 0; i < NC; i++) begin
            if (mdl_valid[i] && (rf_mem[mdl_addr[i]] !== mdl_data[i])) begin
                if (exp_fc == 0) exp_ff = i;
                exp_fc++;
            end
        end
        if (halt_at >= 1 && halt_at <= MAXC) begin
            halt_cyc = halt_at;
            exp_to   = 1'b0;
        end else begin
            halt_cyc = MAXC;
            exp_to   = 1'b1;
        end

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val({name, ".start_busy"}, 32'(busy), 32'd1);
        check_val({name, ".start_done"}, 32'(done), 32'd0);
        check_val({name, ".start_cycles"}, 32'(cycles), 32'd0);
        check_val({name, ".start_fail"}, 32'(fail_count), 32'd0);

        for (int k = 1; k <= halt_cyc; k++) begin
            illegal = (k == halt_at);
            if (k == 2) begin
                // Poisoned write during RUN: a valid, mismatching entry.
                wa        = AW'($urandom_range(0, 31));
                exp_we    = 1'b1;
                exp_idx   = IW'($urandom_range(0, NC - 1));
                exp_valid = 1'b1;
                exp_addr  = wa;
                exp_data  = rf_mem[wa] ^ 32'd1;
            end else begin
                exp_we = 1'b0;
            end
            @(posedge clk); #1;
        end
        exp_we = 1'b0;
        check_val({name, ".cycles"}, 32'(cycles), 32'(halt_cyc));
        check_val({name, ".timeout"}, 32'(timeout), 32'(exp_to));

        lat = -1;
        for (int j = 0; j < 64 && lat < 0; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            illegal = 1'($urandom_range(0, 1));
            if (j >= DC && j - DC < NC)
                check_val({name, ".rf_addr"}, 32'(rf_addr), 32'(mdl_addr[j - DC]));
            if (done) lat = j;
        end
        illegal = 1'b0;
        check_val({name, ".latency"}, 32'(lat), 32'(DC + NC + 2));
        check_val({name, ".busy"}, 32'(busy), 32'd0);
        check_val({name, ".fail_count"}, 32'(fail_count), 32'(exp_fc));
        check_val({name, ".first_fail"}, 32'(first_fail), 32'(exp_ff));
        check_val({name, ".cycles_hold"}, 32'(cycles), 32'(halt_cyc));
        check_val({name, ".timeout_hold"}, 32'(timeout), 32'(exp_to));
        check_val({name, ".pass"}, 32'(pass), 32'((exp_fc == 0) && !exp_to));
        @(posedge clk); #1;
        check_val({name, ".done_hold"}, 32'(done), 32'd1);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        clear_model();

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        // andi smoke: x5 must hold 5, halt on RUN cycle 10.
        rf_mem[5] = 32'd5;
        wr_entry(0, 1'b1, 5'd5, 32'd5);
        for (int i = 1; i < NC; i++) wr_entry(i, 1'b0, 5'd0, 32'd0);
        run_test("andi", 10);

        // Entries 1 and 3 wrong.
        base = $urandom_range(1, 27);
        for (int i = 0; i < NC; i++) begin
            if (i == 1 || i == 3)
                wr_entry(i, 1'b1, AW'(base + i), rf_mem[base + i] ^ ($urandom | 32'd1));
            else
                wr_entry(i, 1'b1, AW'(base + i), rf_mem[base + i]);
        end
        run_test("mismatch", $urandom_range(1, 20));
        run_test("mismatch_again", $urandom_range(1, 20));

        // All entries match, but the budget runs out.
        for (int i = 0; i < NC; i++) wr_entry(i, 1'b1, AW'(base + i), rf_mem[base + i]);
        run_test("timeout", 0);
        run_test("tie", MAXC);
        run_test("halt_first", 1);

        for (int r = 0; r < 8; r++) begin
            rand_table();
            run_test("random", $urandom_range(0, 40));
        end

        // Reset pulsed while CHECK is in progress.
        for (int i = 0; i < NC; i++) wr_entry(i, 1'b1, AW'(base + i), rf_mem[base + i] ^ 32'd2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            illegal = (k == 3);
            @(posedge clk); #1;
        end
        illegal = 1'b0;
        repeat (DC + 2) @(posedge clk);
        #1;
        check_val("midcheck.busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #2;
        check_all_zero("midreset");
        @(posedge clk); #1;
        rstn = 1'b1;
        clear_model();
        run_test("after_reset", 7);

        check_val("rf_data_sanity", rf_mem[0] ^ rf_mem[0], 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=expired expected=finish");
        $fatal(1);
    end

endmodule
